// File: rtl/synch_fifo.sv
// synch_fifo: single-clock FIFO with registered read data and full/empty flags.
// Define SYNCH_FIFO_STATUS_EN to add count/overflow/underflow status outputs.
`default_nettype none

module synch_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 8,
    parameter int ADDR_WIDTH = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic                  rd_en,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic                  full,
    output logic                  empty,
    output logic [DATA_WIDTH-1:0] data_out
`ifdef SYNCH_FIFO_STATUS_EN
    ,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  overflow,
    output logic                  underflow
`endif
);

    localparam logic [ADDR_WIDTH:0] PTR_ONE = 1;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [ADDR_WIDTH:0]   wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH:0]   rd_ptr_q, rd_ptr_d;
    logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
    logic                  wr_acc;
    logic                  rd_acc;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[ADDR_WIDTH] != rd_ptr_q[ADDR_WIDTH]) &&
                   (wr_ptr_q[ADDR_WIDTH-1:0] == rd_ptr_q[ADDR_WIDTH-1:0]);

    assign wr_acc   = wr_en & ~full;
    assign rd_acc   = rd_en & ~empty;
    assign data_out = data_out_q;

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        data_out_d = data_out_q;
        if (wr_acc) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (rd_acc) begin
            rd_ptr_d   = rd_ptr_q + PTR_ONE;
            data_out_d = mem_q[rd_ptr_q[ADDR_WIDTH-1:0]];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            data_out_q <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            data_out_q <= data_out_d;
        end
    end

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem_q[wr_ptr_q[ADDR_WIDTH-1:0]] <= data_in;
        end
    end

`ifdef SYNCH_FIFO_STATUS_EN
    logic overflow_q;
    logic underflow_q;

    assign count     = wr_ptr_q - rd_ptr_q;
    assign overflow  = overflow_q;
    assign underflow = underflow_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            overflow_q  <= wr_en & full;
            underflow_q <= rd_en & empty;
        end
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_synch_fifo.sv
// tb_synch_fifo: directed and random checks of synch_fifo against a queue-based model.
`default_nettype none

module tb_synch_fifo;

    localparam int DW    = 8;
    localparam int DEPTH = 8;
    localparam int AW    = 3;

    logic          clk;
    logic          rst;
    logic          wr_en;
    logic          rd_en;
    logic [DW-1:0] data_in;
    logic          full;
    logic          empty;
    logic [DW-1:0] data_out;
`ifdef SYNCH_FIFO_STATUS_EN
    logic [AW:0]   count;
    logic          overflow;
    logic          underflow;
`endif

    synch_fifo #(
        .DATA_WIDTH (DW),
        .DEPTH      (DEPTH),
        .ADDR_WIDTH (AW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (wr_en),
        .rd_en     (rd_en),
        .data_in   (data_in),
        .full      (full),
        .empty     (empty),
        .data_out  (data_out)
`ifdef SYNCH_FIFO_STATUS_EN
        ,
        .count     (count),
        .overflow  (overflow),
        .underflow (underflow)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int            tests = 0;
    int            fails = 0;
    logic [DW-1:0] model_q[$];
    logic [DW-1:0] model_dout;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_flags(input string tag);
        check({tag, "_empty"}, 32'(empty), 32'(model_q.size() == 0));
        check({tag, "_full"},  32'(full),  32'(model_q.size() == DEPTH));
        check({tag, "_dout"},  32'(data_out), 32'(model_dout));
`ifdef SYNCH_FIFO_STATUS_EN
        check({tag, "_count"}, 32'(count), 32'(model_q.size()));
`endif
    endtask

    // One clock: drive inputs, let the edge happen, advance the model, compare.
    task automatic step(input logic w, input logic r, input logic [DW-1:0] d, input string tag);
        int   occ;
        logic wa;
        logic ra;
        wr_en   = w;
        rd_en   = r;
        data_in = d;
        occ     = model_q.size();
        @(posedge clk);
        wa = w && (occ < DEPTH);
        ra = r && (occ > 0);
        if (ra) model_dout = model_q.pop_front();
        if (wa) model_q.push_back(d);
        #1;
        check_flags(tag);
`ifdef SYNCH_FIFO_STATUS_EN
        check({tag, "_ovf"}, 32'(overflow),  32'(w && occ == DEPTH));
        check({tag, "_unf"}, 32'(underflow), 32'(r && occ == 0));
`endif
        wr_en = 1'b0;
        rd_en = 1'b0;
    endtask

    initial begin
        logic [DW-1:0] pat[5];
        int            wp;
        int            rp;
        pat[0] = 8'h24; pat[1] = 8'h81; pat[2] = 8'h09; pat[3] = 8'h63; pat[4] = 8'h0D;
        model_dout = '0;
        wr_en      = 1'b0;
        rd_en      = 1'b0;
        data_in    = '0;
        rst        = 1'b0;
        #10;
        check_flags("reset");
        #2 rst = 1'b1;
        @(posedge clk);
        #1;
        check_flags("post_reset");

        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, pat[i], "w5");
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b1, 8'h00, "r5");
            check("r5_order", 32'(data_out), 32'(pat[i]));
        end
        step(1'b0, 1'b1, 8'h00, "rd_empty");
        check("rd_empty_hold", 32'(data_out), 32'h0D);

        for (int i = 1; i <= 8; i++) step(1'b1, 1'b0, 8'(i), "fill");
        check("fill_full", 32'(full), 32'h1);
        step(1'b1, 1'b0, 8'hFF, "ovf_write");
        for (int i = 1; i <= 8; i++) begin
            step(1'b0, 1'b1, 8'h00, "drain");
            check("drain_val", 32'(data_out), 32'(i));
        end

        for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 8'(8'h30 + i), "pre_wrap_w");
        for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 8'h00, "pre_wrap_r");
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 8'(8'hA0 + i), "wrap_w");
        check("wrap_full", 32'(full), 32'h1);
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 1'b1, 8'h00, "wrap_r");
            check("wrap_val", 32'(data_out), 32'(8'hA0 + i));
        end

        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 8'(8'h10 + i), "sim_pre");
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 8'(8'h20 + i), "sim_rw");
        check("sim_occ_empty", 32'(empty), 32'h0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 8'h00, "sim_drain");
        check("sim_last", 32'(data_out), 32'h23);
        step(1'b1, 1'b1, 8'h77, "rw_on_empty");
        check("rw_empty_hold", 32'(data_out), 32'h23);
        for (int i = 0; i < 7; i++) step(1'b1, 1'b0, 8'(8'h40 + i), "to_full");
        step(1'b1, 1'b1, 8'hEE, "rw_on_full");
        check("rw_full_dout", 32'(data_out), 32'h77);
        for (int i = 0; i < 7; i++) step(1'b0, 1'b1, 8'h00, "full_drain");
        check("full_drain_last", 32'(data_out), 32'h46);

        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 8'(8'h90 + i), "pre_rst");
        #1 rst = 1'b0;
        model_q.delete();
        model_dout = '0;
        #2;
        check_flags("mid_reset");
        #1 rst = 1'b1;
        @(posedge clk);
        #1;
        step(1'b1, 1'b0, 8'h5A, "post_rst_w");
        step(1'b0, 1'b1, 8'h00, "post_rst_r");
        check("post_rst_5a", 32'(data_out), 32'h5A);

        for (int i = 0; i < 400; i++) begin
            case (i / 100)
                0:       begin wp = 80; rp = 30; end
                1:       begin wp = 30; rp = 80; end
                2:       begin wp = 50; rp = 50; end
                default: begin wp = 90; rp = 90; end
            endcase
            step($urandom_range(0, 99) < wp, $urandom_range(0, 99) < rp,
                 8'($urandom), "rand");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
